// File: rtl/mask_scan_pkg.sv
// Shared types for the mask_scan bit-index serialiser.
// Optional feature macro used by the design: MASK_SCAN_COUNT_EN.
package mask_scan_pkg;

    localparam logic [0:0] ST_IDLE_C = 1'b0;
    localparam logic [0:0] ST_SCAN_C = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE_C,
        SCAN = ST_SCAN_C
    } state_t;

    typedef enum logic [0:0] {
        SCAN_LSB_FIRST = 1'b0,
        SCAN_MSB_FIRST = 1'b1
    } dir_t;

endpackage

// File: rtl/mask_scan_priority_enc.sv
// Priority encoder: picks the lowest (dir=0) or highest (dir=1) set bit of a
// vector and returns its index, a one-hot clear mask, and single/zero flags.
module priority_enc
    import mask_scan_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             dir,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] clear_mask,
    output logic             single,
    output logic             zero
);

    // Select the winning bit; the last match in loop order wins.
    always_comb begin
        index = '0;
        if (dir == SCAN_MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) index = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) index = IDX_W'(i);
            end
        end
    end

    // Flags and the one-hot mask that removes the selected bit.
    always_comb begin
        zero       = (vec == '0);
        single     = !zero && ((vec & (vec - WIDTH'(1))) == '0);
        clear_mask = zero ? '0 : (WIDTH'(1) << index);
    end

endmodule

// File: rtl/mask_scan.sv
// mask_scan: registers in & mask on an accepted start, then emits the index of
// every set bit, one per idx_valid/idx_ready handshake, LSB- or MSB-first.
// Optional feature macro: MASK_SCAN_COUNT_EN adds count/remaining outputs.
//
// state | meaning
// IDLE  | waiting for start; start_ready=1
// SCAN  | presenting indices of pending set bits; busy=1, idx_valid=1
module mask_scan
    import mask_scan_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] mask,
    input  logic             dir,
    output logic [WIDTH-1:0] filtered,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
`ifdef MASK_SCAN_COUNT_EN
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] remaining,
`endif
    output logic             busy,
    output logic             done
);

    state_t           state;
    dir_t             dir_q;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] masked;
    logic [IDX_W-1:0] enc_index;
    logic [WIDTH-1:0] enc_clear;
    logic             enc_single;
    logic             enc_zero;
    logic             accept;
    logic             transfer;

    priority_enc #(.WIDTH(WIDTH)) u_enc (
        .vec        (pending),
        .dir        (dir_q == SCAN_MSB_FIRST),
        .index      (enc_index),
        .clear_mask (enc_clear),
        .single     (enc_single),
        .zero       (enc_zero)
    );

    // Handshake qualifiers and outputs, all derived from registered state.
    always_comb begin
        masked      = in & mask;
        start_ready = (state == IDLE);
        busy        = (state == SCAN);
        idx_valid   = (state == SCAN) && !enc_zero;
        idx         = idx_valid ? enc_index : '0;
        idx_last    = idx_valid && enc_single;
        accept      = start_ready && start;
        transfer    = idx_valid && idx_ready;
    end

    // FSM, pending vector and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dir_q    <= SCAN_LSB_FIRST;
            pending  <= '0;
            filtered <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        filtered <= masked;
                        pending  <= masked;
                        dir_q    <= dir_t'(dir);
                        if (masked != '0) state <= SCAN;
                        else              done  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (transfer) begin
                        pending <= pending & ~enc_clear;
                        if (enc_single) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MASK_SCAN_COUNT_EN
    logic [CNT_W-1:0] masked_pop;

    // Population count of the word being accepted.
    always_comb begin
        masked_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            masked_pop = masked_pop + CNT_W'(masked[i]);
        end
    end

    // Total bit count latched at start; remaining tracks pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            remaining <= '0;
        end else if (accept) begin
            count     <= masked_pop;
            remaining <= masked_pop;
        end else if (transfer) begin
            remaining <= remaining - CNT_W'(1);
        end
    end
`endif

endmodule
